// File: rtl/baud_pkg.sv
// Shared types and constants for the UART baud-rate scheduler.
// The state enum is used by the top-level FSM; MIN_DIVISOR bounds the legal divisors.
package baud_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MIN_DIVISOR   = 2;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Divide counter producing a one-cycle tick and a 50% clk_div per divisor period.
// 'terminal' marks the edge that ends a period, which the scheduler uses to swap divisors.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] divisor,
    output logic             terminal,
    output logic             tick,
    output logic             clk_div
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             div_q, div_d;

    // Compare at full WIDTH; divisor is always >= 2 so divisor-1 never wraps.
    assign terminal = enable && (cnt_q == divisor - WIDTH'(1));

    always_comb begin
        cnt_d  = cnt_q + WIDTH'(1);
        tick_d = 1'b0;
        div_d  = div_q;
        if (!enable) begin
            cnt_d = '0;
            div_d = 1'b0;
        end else if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = ~div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            div_q  <= div_d;
        end
    end

    assign tick    = tick_q;
    assign clk_div = div_q;

endmodule

// File: rtl/baud_rate_scheduler.sv
// Baud clock controller: arbitrates divisor-change requests from two requesters and
// applies an accepted divisor only at a period boundary so no runt period is produced.
module baud_rate_scheduler
    import baud_pkg::*;
#(
    parameter int          WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned RESET_DIVISOR = 868
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_divisor0,
    input  logic [WIDTH-1:0] req_divisor1,
    output logic [1:0]       req_ready,
    output logic             req_err,
    output logic             tick,
    output logic             clk_div,
    output logic [WIDTH-1:0] cur_divisor,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIVISOR);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ptr_q, ptr_d;

    logic [WIDTH-1:0] req_div [2];
    logic             grant_idx;
    logic [WIDTH-1:0] granted_div;
    logic             xfer;
    logic             terminal;

    assign req_div[0] = req_divisor0;
    assign req_div[1] = req_divisor1;
    assign busy       = (state_q == PEND);

    // A requester wins if it is the only one asking, or if the pointer favours it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign req_ready[gi] = !reset && !busy && req_valid[gi] &&
                               (!req_valid[1-gi] || (ptr_q == 1'(gi)));
    end

    assign grant_idx   = req_ready[1];
    assign granted_div = req_div[grant_idx];
    assign xfer        = |req_ready;
    assign req_err     = xfer && (granted_div < WIDTH'(MIN_DIVISOR));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            ptr_d = ~grant_idx;
        end
        case (state_q)
            PEND: begin
                // With the divider stopped there is no period to finish, so apply at once.
                if (!enable || terminal) begin
                    cur_d   = pend_q;
                    state_d = enable ? RUN : OFF;
                end
            end
            default: begin
                state_d = enable ? RUN : OFF;
                if (xfer && !req_err) begin
                    pend_d  = granted_div;
                    state_d = PEND;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
            cur_q   <= RESET_DIV_W;
            pend_q  <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cur_divisor = cur_q;

    baud_tick_gen #(
        .WIDTH (WIDTH)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .divisor  (cur_q),
        .terminal (terminal),
        .tick     (tick),
        .clk_div  (clk_div)
    );

endmodule

// File: tb/tb_baud_rate_scheduler.sv
// Self-checking bench: expected tick times and clk_div levels are queued when the
// stimulus is driven and compared by a monitor whenever the DUT pulses tick.
module tb_baud_rate_scheduler;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   req_valid;
    logic [W-1:0] req_divisor0;
    logic [W-1:0] req_divisor1;
    logic [1:0]   req_ready;
    logic         req_err;
    logic         tick;
    logic         clk_div;
    logic [W-1:0] cur_divisor;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int   at;
        logic div;
    } tick_exp_t;

    tick_exp_t sb[$];

    baud_rate_scheduler #(
        .WIDTH         (W),
        .RESET_DIVISOR (868)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_divisor0 (req_divisor0),
        .req_divisor1 (req_divisor1),
        .req_ready    (req_ready),
        .req_err      (req_err),
        .tick         (tick),
        .clk_div      (clk_div),
        .cur_divisor  (cur_divisor),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic push_tick(input int at, input logic div);
        tick_exp_t e;
        e.at  = at;
        e.div = div;
        sb.push_back(e);
    endtask

    // Called only at falling edges; cyc is bounded by the running clock.
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (tick) begin
            if (sb.size() == 0) begin
                check("tick_unexpected", tick, 1'b0);
            end else begin
                tick_exp_t e;
                e = sb.pop_front();
                check("tick_cycle", cyc, e.at);
                check("clk_div_at_tick", clk_div, e.div);
            end
        end
    end

    int p;
    int q;

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        req_valid    = 2'b00;
        req_divisor0 = '0;
        req_divisor1 = '0;

        // Reset: requests are never granted while reset is high.
        wait_until(1);
        req_valid    = 2'b01;
        req_divisor0 = 50;
        #1;
        check("ready_in_reset", req_ready, 2'b00);
        check("err_in_reset", req_err, 1'b0);
        wait_until(3);
        req_valid = 2'b00;
        check("rst_tick", tick, 1'b0);
        check("rst_clk_div", clk_div, 1'b0);
        check("rst_cur_divisor", cur_divisor, 868);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // D = 868 from enable, then a mid-period change to 10 at counter = 5.
        p = 5;
        wait_until(p);
        enable = 1'b1;
        push_tick(p + 868, 1'b1);
        push_tick(p + 1736, 1'b0);
        push_tick(p + 2604, 1'b1);
        push_tick(p + 2614, 1'b0);
        push_tick(p + 2624, 1'b1);
        push_tick(p + 2634, 1'b0);
        push_tick(p + 2654, 1'b1);
        push_tick(p + 2684, 1'b0);
        push_tick(p + 2724, 1'b1);
        wait_until(p + 1741);
        req_valid    = 2'b01;
        req_divisor0 = 10;
        #1;
        check("midper_ready", req_ready, 2'b01);
        check("midper_err", req_err, 1'b0);
        wait_until(p + 1742);
        req_valid = 2'b00;
        #1;
        check("midper_busy", busy, 1'b1);
        check("busy_blocks_ready", req_ready, 2'b00);
        wait_until(p + 2603);
        check("pend_busy_before_apply", busy, 1'b1);
        check("pend_cur_old", cur_divisor, 868);
        wait_until(p + 2604);
        check("apply_busy", busy, 1'b0);
        check("apply_cur", cur_divisor, 10);

        // Requester 1 sends an illegal divisor: flagged and dropped, pointer still moves.
        wait_until(p + 2626);
        req_valid    = 2'b10;
        req_divisor1 = 1;
        #1;
        check("rej_ready", req_ready, 2'b10);
        check("rej_err", req_err, 1'b1);
        wait_until(p + 2627);
        req_valid = 2'b00;
        #1;
        check("rej_busy", busy, 1'b0);
        check("rej_cur", cur_divisor, 10);

        // Contention: requester 0 then requester 1, then requester 0 again.
        wait_until(p + 2628);
        req_valid    = 2'b11;
        req_divisor0 = 20;
        req_divisor1 = 30;
        #1;
        check("cont1_ready", req_ready, 2'b01);
        wait_until(p + 2629);
        req_valid = 2'b10;
        #1;
        check("cont1_busy", busy, 1'b1);
        check("cont1_ready_blocked", req_ready, 2'b00);
        wait_until(p + 2634);
        check("cont1_cur", cur_divisor, 20);
        check("cont2_ready", req_ready, 2'b10);
        wait_until(p + 2635);
        req_valid = 2'b00;
        #1;
        check("cont2_busy", busy, 1'b1);
        wait_until(p + 2654);
        check("cont2_cur", cur_divisor, 30);
        check("cont2_busy_clear", busy, 1'b0);
        wait_until(p + 2656);
        req_valid    = 2'b11;
        req_divisor0 = 40;
        req_divisor1 = 50;
        #1;
        check("cont3_ready", req_ready, 2'b01);
        wait_until(p + 2657);
        req_valid = 2'b00;
        wait_until(p + 2684);
        check("cont3_cur", cur_divisor, 40);

        // Enable drop: no tick on that edge and clk_div returns to 0.
        wait_until(p + 2730);
        check("pre_drop_clk_div", clk_div, 1'b1);
        enable = 1'b0;
        wait_until(p + 2731);
        check("drop_clk_div", clk_div, 1'b0);
        check("drop_tick", tick, 1'b0);

        // Request while disabled is applied on the following edge.
        wait_until(p + 2732);
        req_valid    = 2'b01;
        req_divisor0 = 4;
        #1;
        check("off_ready", req_ready, 2'b01);
        wait_until(p + 2733);
        req_valid = 2'b00;
        check("off_busy", busy, 1'b1);
        wait_until(p + 2734);
        check("off_apply_busy", busy, 1'b0);
        check("off_apply_cur", cur_divisor, 4);
        q = p + 2736;
        wait_until(q);
        enable = 1'b1;
        push_tick(q + 4, 1'b1);
        push_tick(q + 8, 1'b0);
        push_tick(q + 12, 1'b1);
        push_tick(q + 16, 1'b0);

        // Reset while a divisor is pending discards it.
        wait_until(q + 18);
        req_valid    = 2'b01;
        req_divisor0 = 100;
        wait_until(q + 19);
        req_valid = 2'b00;
        check("rstpend_busy", busy, 1'b1);
        reset        = 1'b1;
        req_valid    = 2'b10;
        req_divisor1 = 7;
        #1;
        check("rstpend_ready", req_ready, 2'b00);
        wait_until(q + 20);
        check("rstpend_cur", cur_divisor, 868);
        check("rstpend_busy_clear", busy, 1'b0);
        check("rstpend_clk_div", clk_div, 1'b0);
        check("rstpend_tick", tick, 1'b0);
        wait_until(q + 21);
        req_valid = 2'b00;
        reset     = 1'b0;
        // Counter restarted from 0: first tick exactly 868 enabled edges later.
        push_tick(q + 21 + 868, 1'b1);
        wait_until(q + 21 + 868 + 3);

        check("ticks_outstanding", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
